// File: rtl/ctrl_pkg.sv
// Shared constants for the CPU control-path pipeline: opcodes, control-bit layout and the bubble value.
package ctrl_pkg;

  localparam int CTRL_W = 4;

  localparam logic [4:0] OP_ALU   = 5'b00000;
  localparam logic [4:0] OP_ADDI  = 5'b00011;
  localparam logic [4:0] OP_05    = 5'b00101;
  localparam logic [4:0] OP_15    = 5'b10101;
  localparam logic [4:0] OP_STORE = 5'b00111;
  localparam logic [4:0] OP_LOAD  = 5'b01000;

  // Control word layout is {reg_we, addr_add, mem_we, wrb_sel}
  localparam int CB_REG_WE   = 3;
  localparam int CB_ADDR_ADD = 2;
  localparam int CB_MEM_WE   = 1;
  localparam int CB_WRB_SEL  = 0;

  typedef logic [CTRL_W-1:0] ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/ctrl_pipe_if.sv
// ID-stage request and EX/MEM/WB control outputs of the control-path pipeline.
interface ctrl_pipe_if
  import ctrl_pkg::*;
#(
  parameter int OPCODE_W = 5,
  parameter int REG_W    = 5
);
  logic                id_valid;
  logic [OPCODE_W-1:0] id_opcode;
  logic [REG_W-1:0]    id_rd;
  logic [REG_W-1:0]    id_rs;
  logic [REG_W-1:0]    id_rt;
  logic                stall_in;
  logic                flush;
  logic                id_ready;
  ctrl_t               ex_ctrl;
  logic                ex_valid;
  ctrl_t               mem_ctrl;
  logic                mem_valid;
  logic                wb_reg_we;
  logic                wb_wrb_sel;
  logic [REG_W-1:0]    wb_rd;
  logic                ex_illegal;

  modport master (
    output id_valid, id_opcode, id_rd, id_rs, id_rt, stall_in, flush,
    input  id_ready, ex_ctrl, ex_valid, mem_ctrl, mem_valid,
           wb_reg_we, wb_wrb_sel, wb_rd, ex_illegal
  );

  modport slave (
    input  id_valid, id_opcode, id_rd, id_rs, id_rt, stall_in, flush,
    output id_ready, ex_ctrl, ex_valid, mem_ctrl, mem_valid,
           wb_reg_we, wb_wrb_sel, wb_rd, ex_illegal
  );
endinterface

// File: rtl/ctrl_decode.sv
// Combinational opcode decoder: control word, load flag and (with CTRL_ILLEGAL_OP_EN) illegal flag.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int OPCODE_W = 5
) (
  input  logic [OPCODE_W-1:0] opcode,
  output ctrl_t               ctrl,
  output logic                is_load,
  output logic                illegal
);

  localparam logic [OPCODE_W-1:0] C_ALU   = OPCODE_W'(OP_ALU);
  localparam logic [OPCODE_W-1:0] C_ADDI  = OPCODE_W'(OP_ADDI);
  localparam logic [OPCODE_W-1:0] C_05    = OPCODE_W'(OP_05);
  localparam logic [OPCODE_W-1:0] C_15    = OPCODE_W'(OP_15);
  localparam logic [OPCODE_W-1:0] C_STORE = OPCODE_W'(OP_STORE);
  localparam logic [OPCODE_W-1:0] C_LOAD  = OPCODE_W'(OP_LOAD);

  always_comb begin
    ctrl    = CTRL_BUBBLE;
    is_load = 1'b0;
    illegal = 1'b0;
    case (opcode)
      C_ALU, C_ADDI, C_05, C_15: ctrl[CB_REG_WE] = 1'b1;
      C_STORE: begin
        ctrl[CB_ADDR_ADD] = 1'b1;
        ctrl[CB_MEM_WE]   = 1'b1;
      end
      C_LOAD: begin
        ctrl[CB_REG_WE]   = 1'b1;
        ctrl[CB_ADDR_ADD] = 1'b1;
        ctrl[CB_WRB_SEL]  = 1'b1;
        is_load           = 1'b1;
      end
      default: begin
`ifdef CTRL_ILLEGAL_OP_EN
        illegal = 1'b1;
`endif
      end
    endcase
  end

endmodule

// File: rtl/ctrl_pipe.sv
// Control-path pipeline ID->EX->MEM->WB with load-use hazard, stall and flush handling.
// Optional CTRL_ILLEGAL_OP_EN flags undecoded opcodes while they sit in EX.
module ctrl_pipe
  import ctrl_pkg::*;
#(
  parameter int OPCODE_W = 5,
  parameter int REG_W    = 5
) (
  input  logic        clock,
  input  logic        reset,
  ctrl_pipe_if.slave  bus
);

  ctrl_t             id_ctrl;
  logic              id_ld;
  logic              id_ill;
  logic              hazard;

  logic              vld_p0, ld_p0, ill_p0;
  ctrl_t             ctrl_p0;
  logic [REG_W-1:0]  rd_p0;
  logic              vld_p1;
  ctrl_t             ctrl_p1;
  logic [REG_W-1:0]  rd_p1;
  logic              vld_p2, we_p2, sel_p2;
  logic [REG_W-1:0]  rd_p2;

  ctrl_decode #(.OPCODE_W(OPCODE_W)) u_decode (
    .opcode  (bus.id_opcode),
    .ctrl    (id_ctrl),
    .is_load (id_ld),
    .illegal (id_ill)
  );

  assign hazard = bus.id_valid & vld_p0 & ld_p0 & (rd_p0 != '0) &
                  ((rd_p0 == bus.id_rs) | (rd_p0 == bus.id_rt));

  always_ff @(posedge clock) begin
    if (!reset) begin
      vld_p0 <= 1'b0; ld_p0 <= 1'b0; ill_p0 <= 1'b0; ctrl_p0 <= CTRL_BUBBLE; rd_p0 <= '0;
      vld_p1 <= 1'b0; ctrl_p1 <= CTRL_BUBBLE; rd_p1 <= '0;
      vld_p2 <= 1'b0; we_p2 <= 1'b0; sel_p2 <= 1'b0; rd_p2 <= '0;
    end else begin
      // ID -> EX: a hazard only bubbles EX when no external stall freezes it
      if (bus.flush || (!bus.stall_in && hazard)) begin
        vld_p0 <= 1'b0; ld_p0 <= 1'b0; ill_p0 <= 1'b0; ctrl_p0 <= CTRL_BUBBLE; rd_p0 <= '0;
      end else if (!bus.stall_in) begin
        vld_p0  <= bus.id_valid;
        ld_p0   <= bus.id_valid & id_ld;
        ill_p0  <= bus.id_valid & id_ill;
        ctrl_p0 <= bus.id_valid ? id_ctrl : CTRL_BUBBLE;
        rd_p0   <= bus.id_valid ? bus.id_rd : '0;
      end
      // EX -> MEM
      if (bus.flush) begin
        vld_p1 <= 1'b0; ctrl_p1 <= CTRL_BUBBLE; rd_p1 <= '0;
      end else if (!bus.stall_in) begin
        vld_p1 <= vld_p0; ctrl_p1 <= ctrl_p0; rd_p1 <= rd_p0;
      end
      // MEM -> WB: a held MEM must not write back twice, so stall inserts a bubble here
      if (bus.flush || !bus.stall_in) begin
        vld_p2 <= vld_p1;
        we_p2  <= ctrl_p1[CB_REG_WE];
        sel_p2 <= ctrl_p1[CB_WRB_SEL];
        rd_p2  <= rd_p1;
      end else begin
        vld_p2 <= 1'b0; we_p2 <= 1'b0; sel_p2 <= 1'b0; rd_p2 <= '0;
      end
    end
  end

  assign bus.id_ready   = bus.flush | (~bus.stall_in & ~hazard);
  assign bus.ex_valid   = vld_p0;
  assign bus.ex_ctrl    = vld_p0 ? ctrl_p0 : CTRL_BUBBLE;
  assign bus.ex_illegal = vld_p0 & ill_p0;
  assign bus.mem_valid  = vld_p1;
  assign bus.mem_ctrl   = vld_p1 ? ctrl_p1 : CTRL_BUBBLE;
  assign bus.wb_reg_we  = vld_p2 & we_p2;
  assign bus.wb_wrb_sel = vld_p2 & sel_p2;
  assign bus.wb_rd      = rd_p2;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Self-checking bench for ctrl_pipe: directed scenarios plus randomized traffic against an opcode-level model.
module tb_ctrl_pipe;

  localparam logic [4:0] ALU = 5'd0, ST = 5'd7, LD = 5'd8, ILL = 5'h1f;
`ifdef CTRL_ILLEGAL_OP_EN
  localparam logic EXP_ILL = 1'b1;
`else
  localparam logic EXP_ILL = 1'b0;
`endif

  typedef struct packed {
    logic r, v; logic [4:0] op, rd, rs, rt; logic st, fl;
  } stim_t;

  typedef struct {
    logic v; logic [4:0] op; logic [4:0] rd;
  } slot_t;

  logic clk = 1'b0;
  logic rst_n;
  int   nvec = 0;
  int   nerr = 0;
  slot_t m_ex, m_mem, m_wb;

  always #5 clk = ~clk;

  ctrl_pipe_if #(.OPCODE_W(5), .REG_W(5)) bus ();

  ctrl_pipe #(.OPCODE_W(5), .REG_W(5)) dut (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  function automatic stim_t rec(logic r, logic v, logic [4:0] op, logic [4:0] rd,
                                logic [4:0] rs, logic [4:0] rt, logic st, logic fl);
    rec = {r, v, op, rd, rs, rt, st, fl};
  endfunction

  // Opcode table as written in the instruction-set description
  function automatic logic [3:0] op_ctrl(logic [4:0] op);
    case (op)
      5'd0, 5'd3, 5'd5, 5'd21: op_ctrl = 4'b1000;
      5'd7:                    op_ctrl = 4'b0110;
      5'd8:                    op_ctrl = 4'b1101;
      default:                 op_ctrl = 4'b0000;
    endcase
  endfunction

  function automatic logic op_known(logic [4:0] op);
    op_known = (op == 5'd0) || (op == 5'd3) || (op == 5'd5) || (op == 5'd21) ||
               (op == 5'd7) || (op == 5'd8);
  endfunction

  function automatic logic m_hazard();
    m_hazard = bus.id_valid && m_ex.v && (m_ex.op == LD) && (m_ex.rd != 5'd0) &&
               ((m_ex.rd == bus.id_rs) || (m_ex.rd == bus.id_rt));
  endfunction

  // {id_ready, ex_valid, ex_ctrl, mem_valid, mem_ctrl, wb_reg_we, wb_wrb_sel, wb_rd, ex_illegal}
  function automatic logic [18:0] dut_vec();
    dut_vec = {bus.id_ready, bus.ex_valid, bus.ex_ctrl, bus.mem_valid, bus.mem_ctrl,
               bus.wb_reg_we, bus.wb_wrb_sel, bus.wb_rd, bus.ex_illegal};
  endfunction

  function automatic logic [18:0] mdl_vec();
    logic [3:0] wbc;
    logic       rdy;
    wbc = m_wb.v ? op_ctrl(m_wb.op) : 4'b0000;
    rdy = bus.flush || (!bus.stall_in && !m_hazard());
    mdl_vec = {rdy, m_ex.v, m_ex.v ? op_ctrl(m_ex.op) : 4'b0000,
               m_mem.v, m_mem.v ? op_ctrl(m_mem.op) : 4'b0000,
               wbc[3], wbc[0], m_wb.v ? m_wb.rd : 5'd0,
               EXP_ILL && m_ex.v && !op_known(m_ex.op)};
  endfunction

  task automatic drive(input stim_t s);
    rst_n         = s.r;
    bus.id_valid  = s.v;
    bus.id_opcode = s.op;
    bus.id_rd     = s.rd;
    bus.id_rs     = s.rs;
    bus.id_rt     = s.rt;
    bus.stall_in  = s.st;
    bus.flush     = s.fl;
  endtask

  // Advance the reference by one clock using the inputs currently applied
  task automatic tick();
    slot_t nb;
    logic  hz;
    nb = '{v: 1'b0, op: 5'd0, rd: 5'd0};
    hz = m_hazard();
    if (!rst_n) begin
      m_ex = nb; m_mem = nb; m_wb = nb;
    end else if (bus.flush) begin
      m_wb = m_mem; m_mem = nb; m_ex = nb;
    end else if (bus.stall_in) begin
      m_wb = nb;
    end else if (hz) begin
      m_wb = m_mem; m_mem = m_ex; m_ex = nb;
    end else begin
      m_wb = m_mem; m_mem = m_ex;
      m_ex = bus.id_valid ? '{v: 1'b1, op: bus.id_opcode, rd: bus.id_rd} : nb;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    stim_t tbl[7];
    logic [18:0] got, exp;
    tbl = '{rec(0,1,ALU,3,0,0,0,0), rec(0,1,ALU,3,0,0,0,0), rec(1,1,ALU,3,0,0,0,0),
            rec(1,0,0,0,0,0,0,0), rec(1,0,0,0,0,0,0,0), rec(1,0,0,0,0,0,0,0),
            rec(1,0,0,0,0,0,0,0)};
    for (int i = 0; i < 7; i++) begin
      drive(tbl[i]); #1;
      got = dut_vec(); exp = mdl_vec(); nvec++;
      if (got !== exp) begin nerr++; $display("FAIL test_reset[%0d] got=%h exp=%h", i, got, exp); end
      if (i < 3) begin
        nvec++;
        if (got[17:0] !== 18'd0) begin nerr++; $display("FAIL reset_zero[%0d] got=%h exp=0", i, got[17:0]); end
      end
      if (i == 5) begin
        nvec++;
        if (bus.wb_reg_we !== 1'b1 || bus.wb_rd !== 5'd3) begin
          nerr++; $display("FAIL reset_alu_wb got we=%b rd=%0d exp we=1 rd=3", bus.wb_reg_we, bus.wb_rd);
        end
      end
      tick();
    end
  endtask

  task automatic test_load_use();
    stim_t tbl[7];
    logic [18:0] got, exp;
    tbl = '{rec(1,1,LD,4,0,0,0,0), rec(1,1,ALU,5,4,1,0,0), rec(1,1,ALU,5,4,1,0,0),
            rec(1,0,0,0,0,0,0,0), rec(1,0,0,0,0,0,0,0), rec(1,0,0,0,0,0,0,0),
            rec(1,0,0,0,0,0,0,0)};
    for (int i = 0; i < 7; i++) begin
      drive(tbl[i]); #1;
      got = dut_vec(); exp = mdl_vec(); nvec++;
      if (got !== exp) begin nerr++; $display("FAIL test_load_use[%0d] got=%h exp=%h", i, got, exp); end
      if (i == 1) begin
        nvec++;
        if (bus.id_ready !== 1'b0) begin nerr++; $display("FAIL hazard_ready got=%b exp=0", bus.id_ready); end
      end
      if (i == 2) begin
        nvec++;
        if (bus.ex_valid !== 1'b0) begin nerr++; $display("FAIL hazard_bubble got=%b exp=0", bus.ex_valid); end
      end
      if (i == 3) begin
        nvec++;
        if (bus.wb_wrb_sel !== 1'b1 || bus.wb_rd !== 5'd4) begin
          nerr++; $display("FAIL load_wb got sel=%b rd=%0d exp sel=1 rd=4", bus.wb_wrb_sel, bus.wb_rd);
        end
      end
      if (i == 5) begin
        nvec++;
        if (bus.wb_reg_we !== 1'b1 || bus.wb_rd !== 5'd5) begin
          nerr++; $display("FAIL hazard_alu_wb got we=%b rd=%0d exp we=1 rd=5", bus.wb_reg_we, bus.wb_rd);
        end
      end
      tick();
    end
  endtask

  task automatic test_stall();
    stim_t tbl[8];
    logic [18:0] got, exp;
    tbl = '{rec(1,1,ALU,2,0,0,0,0), rec(1,1,ST,6,2,3,0,0), rec(1,0,0,0,0,0,0,0),
            rec(1,0,0,0,0,0,1,0), rec(1,0,0,0,0,0,1,0), rec(1,0,0,0,0,0,0,0),
            rec(1,0,0,0,0,0,0,0), rec(1,0,0,0,0,0,0,0)};
    for (int i = 0; i < 8; i++) begin
      drive(tbl[i]); #1;
      got = dut_vec(); exp = mdl_vec(); nvec++;
      if (got !== exp) begin nerr++; $display("FAIL test_stall[%0d] got=%h exp=%h", i, got, exp); end
      if (i >= 3 && i <= 5) begin
        nvec++;
        if (bus.mem_ctrl !== 4'b0110) begin nerr++; $display("FAIL stall_mem_hold[%0d] got=%b exp=0110", i, bus.mem_ctrl); end
      end
      if (i == 3) begin
        nvec++;
        if (bus.wb_reg_we !== 1'b1 || bus.id_ready !== 1'b0) begin
          nerr++; $display("FAIL stall_entry got we=%b rdy=%b exp we=1 rdy=0", bus.wb_reg_we, bus.id_ready);
        end
      end
      if (i == 4) begin
        nvec++;
        if (bus.wb_reg_we !== 1'b0) begin nerr++; $display("FAIL stall_no_dup_wb got=%b exp=0", bus.wb_reg_we); end
      end
      tick();
    end
  endtask

  task automatic test_flush();
    stim_t tbl[6];
    logic [18:0] got, exp;
    tbl = '{rec(1,1,LD,4,0,0,0,0), rec(1,1,ALU,5,4,0,0,1), rec(1,0,0,0,0,0,0,0),
            rec(1,0,0,0,0,0,0,0), rec(1,0,0,0,0,0,0,0), rec(1,0,0,0,0,0,0,0)};
    for (int i = 0; i < 6; i++) begin
      drive(tbl[i]); #1;
      got = dut_vec(); exp = mdl_vec(); nvec++;
      if (got !== exp) begin nerr++; $display("FAIL test_flush[%0d] got=%h exp=%h", i, got, exp); end
      if (i == 1) begin
        nvec++;
        if (bus.id_ready !== 1'b1) begin nerr++; $display("FAIL flush_ready got=%b exp=1", bus.id_ready); end
      end
      if (i == 2) begin
        nvec++;
        if (bus.ex_valid !== 1'b0 || bus.mem_valid !== 1'b0) begin
          nerr++; $display("FAIL flush_kill got ex=%b mem=%b exp 0 0", bus.ex_valid, bus.mem_valid);
        end
      end
      tick();
    end
  endtask

  task automatic test_stall_flush();
    stim_t tbl[6];
    logic [18:0] got, exp;
    tbl = '{rec(1,1,ALU,1,0,0,0,0), rec(1,1,ALU,2,0,0,0,0), rec(1,1,ALU,3,0,0,1,1),
            rec(1,0,0,0,0,0,0,0), rec(1,0,0,0,0,0,0,0), rec(1,0,0,0,0,0,0,0)};
    for (int i = 0; i < 6; i++) begin
      drive(tbl[i]); #1;
      got = dut_vec(); exp = mdl_vec(); nvec++;
      if (got !== exp) begin nerr++; $display("FAIL test_stall_flush[%0d] got=%h exp=%h", i, got, exp); end
      if (i == 2) begin
        nvec++;
        if (bus.id_ready !== 1'b1) begin nerr++; $display("FAIL sf_ready got=%b exp=1", bus.id_ready); end
      end
      if (i == 3) begin
        nvec++;
        if (bus.ex_valid !== 1'b0 || bus.mem_valid !== 1'b0 || bus.wb_reg_we !== 1'b1 || bus.wb_rd !== 5'd1) begin
          nerr++; $display("FAIL sf_state got ex=%b mem=%b we=%b rd=%0d exp 0 0 1 1",
                           bus.ex_valid, bus.mem_valid, bus.wb_reg_we, bus.wb_rd);
        end
      end
      tick();
    end
  endtask

  task automatic test_illegal();
    stim_t tbl[9];
    logic [18:0] got, exp;
    tbl = '{rec(1,1,ILL,9,0,0,0,0), rec(1,0,0,0,0,0,1,0), rec(1,0,0,0,0,0,0,1),
            rec(1,0,0,0,0,0,0,0), rec(1,1,ILL,9,0,0,0,0), rec(1,0,0,0,0,0,0,0),
            rec(1,0,0,0,0,0,0,0), rec(1,0,0,0,0,0,0,0), rec(1,0,0,0,0,0,0,0)};
    for (int i = 0; i < 9; i++) begin
      drive(tbl[i]); #1;
      got = dut_vec(); exp = mdl_vec(); nvec++;
      if (got !== exp) begin nerr++; $display("FAIL test_illegal[%0d] got=%h exp=%h", i, got, exp); end
      if (i == 1 || i == 2 || i == 5) begin
        nvec++;
        if (bus.ex_valid !== 1'b1 || bus.ex_ctrl !== 4'b0000 || bus.ex_illegal !== EXP_ILL) begin
          nerr++; $display("FAIL illegal_in_ex[%0d] got v=%b c=%b ill=%b exp v=1 c=0000 ill=%b",
                           i, bus.ex_valid, bus.ex_ctrl, bus.ex_illegal, EXP_ILL);
        end
      end
      if (i == 3 || i == 6) begin
        nvec++;
        if (bus.ex_illegal !== 1'b0) begin nerr++; $display("FAIL illegal_clear[%0d] got=%b exp=0", i, bus.ex_illegal); end
      end
      tick();
    end
  endtask

  task automatic test_random();
    stim_t s;
    logic [18:0] got, exp;
    logic [4:0] legal [6];
    legal = '{5'd0, 5'd3, 5'd5, 5'd21, 5'd7, 5'd8};
    for (int i = 0; i < 400; i++) begin
      s.r  = ($urandom_range(0, 49) != 0);
      s.v  = ($urandom_range(0, 4) != 0);
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: s.op = legal[$urandom_range(0, 5)];
        6, 7:             s.op = LD;
        default:          s.op = 5'($urandom_range(0, 31));
      endcase
      s.rd = 5'($urandom_range(0, 3));
      s.rs = 5'($urandom_range(0, 3));
      s.rt = 5'($urandom_range(0, 3));
      s.st = ($urandom_range(0, 6) == 0);
      s.fl = ($urandom_range(0, 9) == 0);
      drive(s); #1;
      got = dut_vec(); exp = mdl_vec(); nvec++;
      if (got !== exp) begin nerr++; $display("FAIL test_random[%0d] got=%h exp=%h", i, got, exp); end
      tick();
    end
  endtask

  initial begin
    m_ex  = '{v: 1'b0, op: 5'd0, rd: 5'd0};
    m_mem = m_ex;
    m_wb  = m_ex;
    drive(rec(0,0,0,0,0,0,0,0));
    tick();
    test_reset();
    test_load_use();
    test_stall();
    test_flush();
    test_stall_flush();
    test_illegal();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
